// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving the select of a shared 8:1 mux, with a registered valid/ready output.
// Optional macro MUX8_SCHED_LOCK_EN adds a per-requester lock that re-grants up to 4 words in a row.
module mux8_rr_sched #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         req,
    input  logic [8*WIDTH-1:0] data,
`ifdef MUX8_SCHED_LOCK_EN
    input  logic [7:0]         lock,
`endif
    output logic [7:0]         ack,
    output logic [7:0]         grant,
    output logic [2:0]         sett,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       grant_q, grant_d;
    logic [2:0]       sett_q, sett_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [2:0] nxt_ptr;
    logic [2:0] search_ptr;
    logic [3:0] arb;
    logic [2:0] win_idx;
    logic       win_ok;

    // Returns {found, index} of the first set request searching upward from p, wrapping.
    function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic       found;
        logic [2:0] idx;
        logic [2:0] cand;
        found = 1'b0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand = p + 3'(k);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign nxt_ptr    = sett_q + 3'd1;
    assign search_ptr = (state_q == StIdle) ? ptr_q : nxt_ptr;
    assign arb        = rr_pick(req, search_ptr);

`ifdef MUX8_SCHED_LOCK_EN
    logic [1:0] burst_q, burst_d;
    logic       lock_hit;

    // The 4th consecutive locked word (burst_q == 3) falls back to normal rotation.
    assign lock_hit = (state_q == StBusy) && lock[sett_q] && req[sett_q] && (burst_q != 2'd3);

    always_comb begin
        burst_d = burst_q;
        if (state_q == StIdle) begin
            burst_d = 2'd0;
        end else if (out_ready) begin
            burst_d = lock_hit ? burst_q + 2'd1 : 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= 2'd0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    always_comb begin
        win_idx = arb[2:0];
        win_ok  = arb[3];
`ifdef MUX8_SCHED_LOCK_EN
        if (lock_hit) begin
            win_idx = sett_q;
            win_ok  = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            grant_q <= 8'd0;
            sett_q  <= 3'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            sett_q  <= sett_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        sett_d  = sett_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (win_ok) begin
                    state_d = StBusy;
                    grant_d = 8'd1 << win_idx;
                    sett_d  = win_idx;
                    data_d  = data[32'(win_idx) * WIDTH +: WIDTH];
                end
            end
            StBusy: begin
                if (out_ready) begin
                    ptr_d = nxt_ptr;
                    if (win_ok) begin
                        grant_d = 8'd1 << win_idx;
                        sett_d  = win_idx;
                        data_d  = data[32'(win_idx) * WIDTH +: WIDTH];
                    end else begin
                        state_d = StIdle;
                        grant_d = 8'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        out_valid = (state_q == StBusy);
        ack       = grant_q & {8{out_ready}};
        grant     = grant_q;
        sett      = sett_q;
        out_data  = data_q;
    end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed self-checking bench for mux8_rr_sched (default build; lock tied low if enabled).
module tb_mux8_rr_sched;

    localparam int unsigned WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic [7:0]         req;
    logic [8*WIDTH-1:0] data;
    logic [7:0]         ack;
    logic [7:0]         grant;
    logic [2:0]         sett;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
`ifdef MUX8_SCHED_LOCK_EN
    logic [7:0]         lock;
`endif

    int checks;
    int errors;

    mux8_rr_sched #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
`ifdef MUX8_SCHED_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .grant     (grant),
        .sett      (sett),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b0;
`ifdef MUX8_SCHED_LOCK_EN
        lock      = 8'h00;
`endif
        for (int i = 0; i < 8; i++) data[i*WIDTH +: WIDTH] = 8'(i);

        // Reset held with all requesting
        step();
        step();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_grant", 32'(grant), 32'h00);
        check("rst_sett", 32'(sett), 32'h0);
        check("rst_ack", 32'(ack), 32'h00);
        check("rst_data", 32'(out_data), 32'h00);

        rst_n = 1'b1;
        step();
        check("post_rst_grant", 32'(grant), 32'h01);
        check("post_rst_sett", 32'(sett), 32'h0);
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_noack", 32'(ack), 32'h00);

        // Drain to idle (ptr -> 1)
        req       = 8'h00;
        out_ready = 1'b1;
        #1;
        check("drain_ack", 32'(ack), 32'h01);
        step();
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_grant", 32'(grant), 32'h00);

        // Single requester 5
        data[5*WIDTH +: WIDTH] = 8'h8D;
        req = 8'h20;
        step();
        check("single_sett", 32'(sett), 32'h5);
        check("single_data", 32'(out_data), 32'h8D);
        check("single_ack", 32'(ack), 32'h20);
        req = 8'h00;
        step();
        check("single_idle_valid", 32'(out_valid), 32'h0);
        check("single_idle_grant", 32'(grant), 32'h00);
        check("single_idle_sett_hold", 32'(sett), 32'h5);
        check("single_idle_noack", 32'(ack), 32'h00);

        // Rotation from ptr 0: pulse reset to restart the pointer
        data[5*WIDTH +: WIDTH] = 8'h05;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req   = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("rot_data_%0d", i), 32'(out_data), 32'(i % 8));
            check($sformatf("rot_ack_%0d", i), 32'(ack), 32'(8'd1 << (i % 8)));
        end
        req = 8'h00;
        step();
        check("rot_idle", 32'(out_valid), 32'h0);

        // Backpressure: ptr is 1, req 0A -> requester 1 then 3
        req       = 8'h0A;
        out_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) req = 8'h0F;
            check($sformatf("bp_grant_%0d", i), 32'(grant), 32'h02);
            check($sformatf("bp_data_%0d", i), 32'(out_data), 32'h01);
            check($sformatf("bp_ack_%0d", i), 32'(ack), 32'h00);
            step();
        end
        req       = 8'h0A;
        out_ready = 1'b1;
        #1;
        check("bp_release_ack", 32'(ack), 32'h02);
        step();
        check("bp_next_grant", 32'(grant), 32'h08);
        check("bp_next_sett", 32'(sett), 32'h3);
        check("bp_next_data", 32'(out_data), 32'h03);

        // Wrap: serve 7, then 81 -> 0
        req = 8'h80;
        step();
        check("wrap_grant7", 32'(grant), 32'h80);
        check("wrap_sett7", 32'(sett), 32'h7);
        req = 8'h81;
        #1;
        check("wrap_ack7", 32'(ack), 32'h80);
        step();
        check("wrap_grant0", 32'(grant), 32'h01);
        check("wrap_sett0", 32'(sett), 32'h0);
        check("wrap_data0", 32'(out_data), 32'h00);

        // Reset while busy
        out_ready = 1'b0;
        step();
        check("busy_before_rst", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'h0);
        check("midrst_grant", 32'(grant), 32'h00);
        out_ready = 1'b1;
        #1;
        check("midrst_ack", 32'(ack), 32'h00);
        step();
        rst_n = 1'b1;
        req   = 8'h84;
        step();
        check("after_rst_grant", 32'(grant), 32'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
